// File: rtl/line_mem_responder.sv
// line_mem_responder: memory-side responder that streams refill lines and absorbs writeback lines
// over a word-addressed backing store with a fixed access latency.
module line_mem_responder #(
  parameter int OFFSET_WIDTH   = 4,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int LATENCY        = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_req,
  input  logic                    i_req_we,
  input  logic [31:0]             i_req_addr,
  input  logic [31:0]             i_wdata,
  input  logic                    i_wdata_valid,
  output logic                    o_ready,
  output logic                    o_rvalid,
  output logic [31:0]             o_rdata,
  output logic [OFFSET_WIDTH-3:0] o_offset,
  output logic                    o_wnext,
  output logic                    o_done
);
  localparam int IW = OFFSET_WIDTH - 2;
  localparam int BW = MEM_ADDR_WIDTH + 2 - OFFSET_WIDTH;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  typedef enum logic [2:0] {IDLE, WAIT, READ, WRITE, DONE} state_t;
  state_t                    r_state, w_next;
  logic [IW-1:0]             r_index;
  logic [BW-1:0]             r_base;
  logic                      r_we;
  logic [CW-1:0]             r_cnt;
  logic [31:0]               r_mem [2**MEM_ADDR_WIDTH];
  logic [MEM_ADDR_WIDTH-1:0] w_addr;
  logic                      w_accept, w_beat, w_last;
  logic                      w_unused;
  // {base,index} is exactly MEM_ADDR_WIDTH wide, so lines past the store wrap naturally
  assign w_addr   = {r_base, r_index};
  assign w_accept = (r_state == IDLE) && i_req;
  assign w_beat   = (r_state == READ) || ((r_state == WRITE) && i_wdata_valid);
  assign w_last   = w_beat && (&r_index);
  assign w_unused = ^{i_req_addr[31:MEM_ADDR_WIDTH+2], i_req_addr[OFFSET_WIDTH-1:0]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        if (i_req) w_next = (LATENCY == 0) ? (i_req_we ? WRITE : READ) : WAIT;
      WAIT:        if (r_cnt == '0) w_next = r_we ? WRITE : READ;
      READ, WRITE: if (w_last) w_next = DONE;
      DONE:        w_next = IDLE;
      default:     w_next = IDLE;
    endcase
    o_ready  = (r_state == IDLE);
    o_rvalid = (r_state == READ);
    o_rdata  = o_rvalid ? r_mem[w_addr] : '0;
    o_offset = r_index;
    o_wnext  = (r_state == WRITE) && i_wdata_valid;
    o_done   = (r_state == DONE);
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_index <= '0;
      r_base  <= '0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_base  <= i_req_addr[MEM_ADDR_WIDTH+1:OFFSET_WIDTH];
        r_we    <= i_req_we;
        r_index <= '0;
        r_cnt   <= CW'(LATENCY - 1);
      end else begin
        if ((r_state == WAIT) && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;
        if (w_beat) r_index <= r_index + 1'b1;
      end
    end
  end
  // backing store is deliberately never reset
  always_ff @(posedge i_clk) begin
    if (o_wnext) r_mem[w_addr] <= i_wdata;
  end
endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: directed checks of latency, refill/writeback beats, address wrap,
// mid-refill reset and held-request acceptance.
module tb_line_mem_responder;
  logic        clk = 0, rst = 1, req = 0, req_we = 0, wdv = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic        ready, rvalid, wnext, done;
  logic [31:0] rdata;
  logic [1:0]  offset;
  int          n_cmp = 0, n_err = 0, n_acc = 0, n0 = 0;
  always #5 clk = ~clk;
  always @(negedge clk) if (req && ready) n_acc++;
  line_mem_responder #(.OFFSET_WIDTH(4), .MEM_ADDR_WIDTH(12), .LATENCY(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_req_we(req_we), .i_req_addr(addr),
    .i_wdata(wdata), .i_wdata_valid(wdv), .o_ready(ready), .o_rvalid(rvalid),
    .o_rdata(rdata), .o_offset(offset), .o_wnext(wnext), .o_done(done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wb(input logic [31:0] a, input logic [31:0] d [4], input logic [5:0] pat, input int n);
    int k = 0;
    req = 1; req_we = 1; addr = a;
    #1 chk("wb_ready_idle", ready, 1);
    cyc();
    req = 0;
    for (int i = 0; i < 4; i++) begin
      chk("wb_wait_ready", ready, 0);
      chk("wb_wait_wnext", wnext, 0);
      cyc();
    end
    for (int i = 0; i < n; i++) begin
      wdv = pat[i];
      wdata = pat[i] ? d[k] : 32'hDEAD_BEEF;
      #1;
      chk("wb_offset", offset, k);
      chk("wb_wnext", wnext, pat[i]);
      if (pat[i]) k++;
      cyc();
    end
    wdv = 0;
    chk("wb_done", done, 1);
    cyc();
    chk("wb_done_clear", done, 0);
    chk("wb_ready_after", ready, 1);
  endtask
  task automatic rf_body(input logic [31:0] d [4], input logic hold);
    for (int i = 0; i < 4; i++) begin
      chk("rf_wait_rvalid", rvalid, 0);
      chk("rf_wait_rdata", rdata, 0);
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      chk("rf_rvalid", rvalid, 1);
      chk("rf_offset", offset, i);
      chk("rf_rdata", rdata, d[i]);
      cyc();
    end
    chk("rf_done", done, 1);
    chk("rf_done_rvalid", rvalid, 0);
    chk("rf_done_ready", ready, 0);
    req = hold;
    cyc();
    chk("rf_done_clear", done, 0);
    chk("rf_ready_after", ready, 1);
  endtask
  task automatic rf(input logic [31:0] a, input logic [31:0] d [4], input logic hold);
    req = 1; req_we = 0; addr = a;
    cyc();
    req = 0;
    rf_body(d, hold);
  endtask
  initial begin
    cyc();
    cyc();
    rst = 0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wnext", wnext, 0);
    chk("rst_done", done, 0);
    chk("rst_offset", offset, 0);
    chk("rst_rdata", rdata, 0);
    wb(32'h0000_0400, '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004}, 6'b001111, 4);
    rf(32'h0000_0400, '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004}, 0);
    wb(32'h0000_0800, '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444}, 6'b101101, 6);
    rf(32'h0000_080C, '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444}, 0);
    wb(32'h0000_4000, '{32'h5A5A_0000, 32'h5A5A_0001, 32'h5A5A_0002, 32'h5A5A_0003}, 6'b001111, 4);
    rf(32'h0000_0000, '{32'h5A5A_0000, 32'h5A5A_0001, 32'h5A5A_0002, 32'h5A5A_0003}, 0);
    req = 1; req_we = 0; addr = 32'h0000_0400;
    cyc();
    req = 0;
    repeat (6) cyc();
    chk("mid_rvalid", rvalid, 1);
    chk("mid_offset", offset, 2);
    rst = 1;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_rvalid", rvalid, 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_offset", offset, 0);
    chk("abort_done", done, 0);
    cyc();
    rst = 0;
    cyc();
    chk("abort_no_done", done, 0);
    chk("abort_idle", ready, 1);
    rf(32'h0000_0400, '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004}, 1);
    n0 = n_acc;
    cyc();
    chk("held_accepted", ready, 0);
    rf_body('{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004}, 0);
    chk("held_accept_count", n_acc - n0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
